comparator_arbiter: RTL and testbench

//   Shares one registered 8-bit magnitude comparator (equal/greater/lesser)

---
 rtl/comparator_arbiter.sv | 133 +++++++++++++
 tb/tb_comparator_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/comparator_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | comparator_arbiter: round-robin access to one registered 8-bit comparator    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic                 equal,
  output logic                 greater,
  output logic                 lesser
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic            eq_q, eq_d;
  logic            gt_q, gt_d;
  logic            lt_q, lt_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [7:0]      win_a;
  logic [7:0]      win_b;
  int              idx;

  // Rotating search: first requester at or after ptr_q, wrapping past NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_a     = '0;
    win_b     = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
        win_a     = req_a[idx*8 +: 8];
        win_b     = req_b[idx*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          a_d     = win_a;
          b_d     = win_b;
          id_d    = win_id;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        eq_d    = (a_q == b_q);
        gt_d    = (a_q > b_q);
        lt_d    = (a_q < b_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == ST_GRANT) begin
      gnt[id_q] = 1'b1;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = id_q;
  assign equal      = eq_q;
  assign greater    = gt_q;
  assign lesser     = lt_q;

endmodule
`default_nettype wire

// File: tb/tb_comparator_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_comparator_arbiter: directed vector bench for comparator_arbiter          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_comparator_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  gnt;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic        equal;
  logic        greater;
  logic        lesser;

  int n_vec  = 0;
  int n_miss = 0;

  comparator_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .equal      (equal),
    .greater    (greater),
    .lesser     (lesser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flg is {equal, greater, lesser}
  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  id;
    logic [2:0]  flg;
  } vec_t;

  localparam logic [31:0] PA = 32'h4B64FF00;  // a3..a0 = 75,100,255,0
  localparam logic [31:0] PB = 32'h4A96FF01;  // b3..b0 = 74,150,255,1
  localparam logic [2:0]  EQ = 3'b100;
  localparam logic [2:0]  GT = 3'b010;
  localparam logic [2:0]  LT = 3'b001;

  vec_t tv[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, equal, greater, lesser};
  endfunction

  // Starts from IDLE at a negedge; ends at the negedge where the FSM is IDLE again.
  task automatic run_txn(input vec_t v, input int n);
    req        = v.req;
    req_a      = v.a;
    req_b      = v.b;
    resp_ready = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d gnt", n), {28'd0, gnt}, 32'(1) << v.id);
    check($sformatf("v%0d valid_in_grant", n), {31'd0, resp_valid}, 32'd0);
    // Withdraw the request and swap operands: the captured pair must be used.
    req   = 4'b0000;
    req_a = v.b;
    req_b = v.a;
    @(negedge clk);
    check($sformatf("v%0d gnt_pulse", n), {28'd0, gnt}, 32'd0);
    check($sformatf("v%0d resp_valid", n), {31'd0, resp_valid}, 32'd1);
    check($sformatf("v%0d resp_id", n), {30'd0, resp_id}, {30'd0, v.id});
    check($sformatf("v%0d flags", n), flags(), {29'd0, v.flg});
    @(negedge clk);
    check($sformatf("v%0d valid_drop", n), {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    tv[0]  = '{4'b0001, 32'h4B64FFC8, 32'h4A96FF64, 2'd0, GT};  // 200 vs 100
    tv[1]  = '{4'b1000, PA, PB, 2'd3, GT};
    tv[2]  = '{4'b1111, PA, PB, 2'd0, LT};
    tv[3]  = '{4'b1111, PA, PB, 2'd1, EQ};
    tv[4]  = '{4'b1111, PA, PB, 2'd2, LT};
    tv[5]  = '{4'b1111, PA, PB, 2'd3, GT};
    tv[6]  = '{4'b1111, PA, PB, 2'd0, LT};
    tv[7]  = '{4'b1000, PA, PB, 2'd3, GT};
    tv[8]  = '{4'b1010, PA, PB, 2'd1, EQ};
    tv[9]  = '{4'b1000, PA, PB, 2'd3, GT};
    tv[10] = '{4'b0110, PA, PB, 2'd1, EQ};
    tv[11] = '{4'b0110, PA, PB, 2'd2, LT};
    tv[12] = '{4'b0011, PA, PB, 2'd0, LT};
    tv[13] = '{4'b0100, 32'h4B00FF00, 32'h4AFFFF01, 2'd2, LT};  // 0 vs 255
    tv[14] = '{4'b1000, 32'hFF64FF00, 32'h0096FF01, 2'd3, GT};  // 255 vs 0

    // Reset with requests pending
    rst        = 1'b1;
    req        = 4'b1111;
    req_a      = PA;
    req_b      = PB;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst gnt", {28'd0, gnt}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_id", {30'd0, resp_id}, 32'd0);
    check("rst flags", flags(), 32'd0);
    rst = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d gnt", i), {28'd0, gnt}, 32'd0);
      check($sformatf("idle%0d resp_valid", i), {31'd0, resp_valid}, 32'd0);
    end

    for (int i = 0; i < 15; i++) run_txn(tv[i], i);

    // Stalled consumer: ptr is 0, requester 2 served while others wait
    req        = 4'b0100;
    req_a      = PA;
    req_b      = PB;
    resp_ready = 1'b0;
    @(negedge clk);
    check("stall gnt", {28'd0, gnt}, 32'h4);
    req = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d gnt", i), {28'd0, gnt}, 32'd0);
      check($sformatf("stall%0d resp_valid", i), {31'd0, resp_valid}, 32'd1);
      check($sformatf("stall%0d resp_id", i), {30'd0, resp_id}, 32'd2);
      check($sformatf("stall%0d flags", i), flags(), {29'd0, LT});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall release valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("post stall gnt", {28'd0, gnt}, 32'h8);
    req = 4'b0000;
    @(negedge clk);
    check("post stall id", {30'd0, resp_id}, 32'd3);
    check("post stall flags", flags(), {29'd0, GT});
    @(negedge clk);
    check("post stall drop", {31'd0, resp_valid}, 32'd0);

    // Move ptr to 1, then abort a transaction in GRANT with reset
    run_txn('{4'b0001, PA, PB, 2'd0, LT}, 20);
    req = 4'b0100;
    @(negedge clk);
    check("abort gnt", {28'd0, gnt}, 32'h4);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check("abort rst gnt", {28'd0, gnt}, 32'd0);
    check("abort rst valid", {31'd0, resp_valid}, 32'd0);
    check("abort rst id", {30'd0, resp_id}, 32'd0);
    check("abort rst flags", flags(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort idle%0d valid", i), {31'd0, resp_valid}, 32'd0);
      check($sformatf("abort idle%0d gnt", i), {28'd0, gnt}, 32'd0);
    end
    // ptr must be back at 0
    run_txn('{4'b1111, PA, PB, 2'd0, LT}, 21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
